// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared FSM states, forwarding selects and comparator helper
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

  // x0 is hardwired to zero, so it never produces a dependency.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] rd, input logic wr);
    return wr && (rd != 5'd0) && (src == rd);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// rtl/pipe_fwd_unit.sv - combinational source/destination comparators for forwarding and RAW detection
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] mem_rd_i,
  input  logic [4:0] wb_rd_i,
  input  logic       ex_reg_write_i,
  input  logic       mem_reg_write_i,
  input  logic       wb_reg_write_i,
  input  logic       ex_mem_read_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       load_use_o,
  output logic       raw_hazard_o
);

  logic rs1_ex_hit, rs2_ex_hit;

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  always_comb begin
    fwd_a_o = FWD_RF;
    if (reg_hit(ex_rs1_i, mem_rd_i, mem_reg_write_i))     fwd_a_o = FWD_EXMEM;
    else if (reg_hit(ex_rs1_i, wb_rd_i, wb_reg_write_i))  fwd_a_o = FWD_MEMWB;
    fwd_b_o = FWD_RF;
    if (reg_hit(ex_rs2_i, mem_rd_i, mem_reg_write_i))     fwd_b_o = FWD_EXMEM;
    else if (reg_hit(ex_rs2_i, wb_rd_i, wb_reg_write_i))  fwd_b_o = FWD_MEMWB;
  end

  assign rs1_ex_hit = id_uses_rs1_i && reg_hit(id_rs1_i, ex_rd_i, 1'b1);
  assign rs2_ex_hit = id_uses_rs2_i && reg_hit(id_rs2_i, ex_rd_i, 1'b1);
  assign load_use_o = ex_mem_read_i && (rs1_ex_hit || rs2_ex_hit);

  // WB matches are omitted: the register file writes before it is read.
  assign raw_hazard_o =
      (id_uses_rs1_i && (reg_hit(id_rs1_i, ex_rd_i, ex_reg_write_i) ||
                         reg_hit(id_rs1_i, mem_rd_i, mem_reg_write_i))) ||
      (id_uses_rs2_i && (reg_hit(id_rs2_i, ex_rd_i, ex_reg_write_i) ||
                         reg_hit(id_rs2_i, mem_rd_i, mem_reg_write_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward controller for the 5-stage pipeline; FWD_EN enables forwarding
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             ex_reg_write,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_e       state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  stall_q;
  logic [1:0]        fwd_a_raw, fwd_b_raw;
  logic              load_use, raw_hazard, hazard_stall, mem_hold, fwd_en;

  pipe_fwd_unit u_fwd (
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .id_uses_rs1_i   (id_uses_rs1),
    .id_uses_rs2_i   (id_uses_rs2),
    .ex_rs1_i        (ex_rs1),
    .ex_rs2_i        (ex_rs2),
    .ex_rd_i         (ex_rd),
    .mem_rd_i        (mem_rd),
    .wb_rd_i         (wb_rd),
    .ex_reg_write_i  (ex_reg_write),
    .mem_reg_write_i (mem_reg_write),
    .wb_reg_write_i  (wb_reg_write),
    .ex_mem_read_i   (ex_mem_read),
    .fwd_a_o         (fwd_a_raw),
    .fwd_b_o         (fwd_b_raw),
    .load_use_o      (load_use),
    .raw_hazard_o    (raw_hazard)
  );

`ifdef FWD_EN
  assign fwd_en = 1'b1;
`else
  assign fwd_en = 1'b0;
`endif

  assign hazard_stall = load_use || (raw_hazard && !fwd_en);
  assign fwd_a        = (reset && fwd_en) ? fwd_a_raw : FWD_RF;
  assign fwd_b        = (reset && fwd_en) ? fwd_b_raw : FWD_RF;

  // The freeze starts in the very cycle the access misses, so the MEM instruction never slips.
  assign mem_hold = ((state_q == ST_RUN) && dmem_req && !dmem_ready) ||
                    ((state_q == ST_MEM_WAIT) && !dmem_ready);

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (!reset || (state_q == ST_ERROR)) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      memwb_bubble = 1'b1;
    end else if (mem_hold) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hazard_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign mem_timeout_err = (state_q == ST_ERROR);
  assign stall_count     = stall_q;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      if (!pc_en && (state_q != ST_ERROR) && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      case (state_q)
        ST_RUN: begin
          if (dmem_req && !dmem_ready) begin
            wait_q  <= WAIT_W'(1);
            state_q <= (MEM_TIMEOUT <= 1) ? ST_ERROR : ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            wait_q  <= '0;
            state_q <= ST_RUN;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
            if (wait_q + WAIT_W'(1) == WAIT_W'(MEM_TIMEOUT))
              state_q <= ST_ERROR;
          end
        end
        ST_ERROR: state_q <= ST_ERROR;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] C_NORMAL = 8'b11111_000;
  localparam logic [7:0] C_FROZEN = 8'b00000_001;
  localparam logic [7:0] C_MWAIT  = 8'b00001_001;
  localparam logic [7:0] C_LDUSE  = 8'b00111_010;
  localparam logic [7:0] C_BRANCH = 8'b11111_110;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_reg_write, mem_reg_write, wb_reg_write;
  logic        ex_mem_read, ex_branch_taken, dmem_req, dmem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, memwb_bubble, mem_timeout_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;
  logic [7:0]  ctl;
  int          checks = 0;
  int          errors = 0;
  int          exp_stall = 0;

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout_err(mem_timeout_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_mem_read = 0; ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++; if (ctl !== C_FROZEN) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, C_FROZEN); end
    checks++; if ({fwd_a, fwd_b, mem_timeout_err} !== 5'b0) begin errors++; $display("FAIL reset_fwd_err got %b exp 00000", {fwd_a, fwd_b, mem_timeout_err}); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall_count got %0d exp 0", stall_count); end
    @(posedge clk); reset = 1'b1; #1;
    checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL post_reset_ctl got %b exp %b", ctl, C_NORMAL); end
  endtask

  task automatic test_load_use();
    @(posedge clk); idle_inputs();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1; #1;
    checks++; if (ctl !== C_LDUSE) begin errors++; $display("FAIL load_use_ctl got %b exp %b", ctl, C_LDUSE); end
    exp_stall = 1;
    @(posedge clk); idle_inputs(); #1;
    checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL load_use_release got %b exp %b", ctl, C_NORMAL); end
    checks++; if (stall_count !== 16'(exp_stall)) begin errors++; $display("FAIL load_use_count got %0d exp %0d", stall_count, exp_stall); end
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 0; #1;
    checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL load_unused_src got %b exp %b", ctl, C_NORMAL); end
  endtask

  task automatic test_x0();
    @(posedge clk); idle_inputs();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    mem_rd = 0; mem_reg_write = 1; ex_rs1 = 0; #1;
    checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL x0_ctl got %b exp %b", ctl, C_NORMAL); end
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL x0_fwd got %b exp 00", fwd_a); end
  endtask

  task automatic test_branch();
    @(posedge clk); idle_inputs();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; ex_branch_taken = 1; #1;
    checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL branch_ctl got %b exp %b", ctl, C_BRANCH); end
    @(posedge clk); idle_inputs(); #1;
    checks++; if (stall_count !== 16'(exp_stall)) begin errors++; $display("FAIL branch_count got %0d exp %0d", stall_count, exp_stall); end
  endtask

  task automatic test_forwarding();
    @(posedge clk); idle_inputs();
    ex_rs1 = 7; mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; id_rs1 = 7; id_uses_rs1 = 1; #1;
`ifdef FWD_EN
    checks++; if ({fwd_a, ctl} !== {2'b10, C_NORMAL}) begin errors++; $display("FAIL fwd_exmem got %b_%b exp 10_%b", fwd_a, ctl, C_NORMAL); end
`else
    checks++; if ({fwd_a, ctl} !== {2'b00, C_LDUSE}) begin errors++; $display("FAIL nofwd_stall got %b_%b exp 00_%b", fwd_a, ctl, C_LDUSE); end
    exp_stall++;
`endif
    @(posedge clk); idle_inputs();
    ex_rs2 = 9; wb_rd = 9; wb_reg_write = 1; mem_rd = 7; mem_reg_write = 1; id_rs1 = 9; id_uses_rs1 = 1; #1;
`ifdef FWD_EN
    checks++; if ({fwd_b, ctl} !== {2'b01, C_NORMAL}) begin errors++; $display("FAIL fwd_memwb got %b_%b exp 01_%b", fwd_b, ctl, C_NORMAL); end
`else
    checks++; if ({fwd_b, ctl} !== {2'b00, C_NORMAL}) begin errors++; $display("FAIL wb_no_stall got %b_%b exp 00_%b", fwd_b, ctl, C_NORMAL); end
`endif
    @(posedge clk); idle_inputs(); #1;
    checks++; if (stall_count !== 16'(exp_stall)) begin errors++; $display("FAIL fwd_count got %0d exp %0d", stall_count, exp_stall); end
  endtask

  task automatic test_mem_wait();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); idle_inputs(); dmem_req = 1; ex_branch_taken = 1; #1;
      checks++; if (ctl !== C_MWAIT) begin errors++; $display("FAIL mem_wait_c%0d got %b exp %b", c, ctl, C_MWAIT); end
    end
    @(posedge clk); dmem_ready = 1; #1;
    checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL mem_release got %b exp %b", ctl, C_BRANCH); end
    exp_stall += 3;
    @(posedge clk); idle_inputs(); #1;
    checks++; if ({ctl, mem_timeout_err} !== {C_NORMAL, 1'b0}) begin errors++; $display("FAIL mem_after got %b exp %b0", {ctl, mem_timeout_err}, C_NORMAL); end
    checks++; if (stall_count !== 16'(exp_stall)) begin errors++; $display("FAIL mem_count got %0d exp %0d", stall_count, exp_stall); end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); idle_inputs(); dmem_req = 1; #1;
      checks++; if ({ctl, mem_timeout_err} !== {C_MWAIT, 1'b0}) begin errors++; $display("FAIL timeout_wait_c%0d got %b exp %b0", c, {ctl, mem_timeout_err}, C_MWAIT); end
    end
    exp_stall += 4;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); if (c > 0) begin dmem_req = 0; dmem_ready = 1; end #1;
      checks++; if ({ctl, mem_timeout_err} !== {C_FROZEN, 1'b1}) begin errors++; $display("FAIL error_sticky_c%0d got %b exp %b1", c, {ctl, mem_timeout_err}, C_FROZEN); end
    end
    checks++; if (stall_count !== 16'(exp_stall)) begin errors++; $display("FAIL error_count got %0d exp %0d", stall_count, exp_stall); end
    @(posedge clk); reset = 1'b0; #1;
    checks++; if ({ctl, mem_timeout_err, stall_count} !== {C_FROZEN, 1'b0, 16'd0}) begin errors++; $display("FAIL error_reset got %b/%0d exp %b0/0", {ctl, mem_timeout_err}, stall_count, C_FROZEN); end
    @(posedge clk); reset = 1'b1; idle_inputs(); #1;
    checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL error_recover got %b exp %b", ctl, C_NORMAL); end
    exp_stall = 0;
  endtask

  task automatic test_reset_mid_wait();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); idle_inputs(); dmem_req = 1;
    end
    @(posedge clk); reset = 1'b0; #1;
    checks++; if ({ctl, stall_count} !== {C_FROZEN, 16'd0}) begin errors++; $display("FAIL midwait_reset got %b/%0d exp %b/0", ctl, stall_count, C_FROZEN); end
    @(posedge clk); reset = 1'b1; idle_inputs(); #1;
    checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL midwait_run got %b exp %b", ctl, C_NORMAL); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); dmem_req = 1; #1;
    end
    @(posedge clk); dmem_ready = 1; #1;
    checks++; if ({ctl, mem_timeout_err} !== {C_NORMAL, 1'b0}) begin errors++; $display("FAIL midwait_counter_cleared got %b exp %b0", {ctl, mem_timeout_err}, C_NORMAL); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_forwarding();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall, flush and forwarding controller for the 5-stage RISC-V pipeline. It drives the enable and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use and branch hazards and freezes the pipeline while the data memory is not ready. It sits beside the datapath in the core top level and clocks on the same falling edge as the pipeline registers.

## Interface
- MEM_TIMEOUT, 15: number of MEM_WAIT cycles before the controller enters ERROR.
- CNT_W, 16: width of the stall counter.

- clk  in  1  core clock; state updates on the falling edge, in step with the pipeline registers
- reset  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX
- ex_rd, mem_rd, wb_rd  in  5 each  destination registers of the instructions in EX, MEM and WB
- ex_reg_write, mem_reg_write, wb_reg_write  in  1 each  the instruction in that stage writes the register file
- ex_mem_read  in  1  the instruction in EX is a load
- ex_branch_taken  in  1  branch or jump resolved taken in EX
- dmem_req  in  1  the MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_flush, idex_flush  out  1 each  load a bubble (all control bits zero)
- memwb_bubble  out  1  zero MemRead, MemWrite, MemToReg and RD into MEM/WB
- fwd_a, fwd_b  out  2 each  ALU operand source: 00 = register file, 10 = EX/MEM, 01 = MEM/WB
- mem_timeout_err  out  1  sticky error flag
- stall_count  out  CNT_W  saturating count of stalled cycles

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. All outputs are combinational from the state and the inputs.
- Output priority: reset asserted > ERROR > MEM_WAIT (not ready) > branch flush > RAW/load-use stall > normal.
- Normal: every enable is 1, every flush/bubble is 0.
- Load-use stall:
  - Condition: ex_mem_read, ex_rd != 0, and ex_rd matches a source the ID instruction actually uses.
  - Response: pc_en = 0, ifid_en = 0, idex_flush = 1. All other enables stay 1.
- Branch: ex_branch_taken gives ifid_flush = 1 and idex_flush = 1, with pc_en = 1. A branch overrides a coincident load-use stall.
- RUN to MEM_WAIT: dmem_req = 1 and dmem_ready = 0.
  - In MEM_WAIT, pc, ifid, idex and exmem enables are 0, memwb_en = 1 and memwb_bubble = 1.
  - The wait counter increments every cycle spent in MEM_WAIT.
- MEM_WAIT with dmem_ready = 1:
  - Outputs in that cycle are as in RUN. Any pending branch flush takes effect in this release cycle.
  - Next state is RUN and the wait counter clears.
- Wait counter reaching MEM_TIMEOUT: next state is ERROR. ERROR is sticky until reset.
  - In ERROR, all enables are 0, memwb_bubble = 1 and mem_timeout_err = 1.
- stall_count increments on every cycle with pc_en = 0 outside ERROR, and saturates at all ones.
- Register x0 never creates a hazard or a forward.

## Timing
- Reset values: state RUN, wait counter 0, stall_count 0, mem_timeout_err 0.
- While reset is asserted, all enables are 0, flushes are 0, memwb_bubble = 1 and fwd_a/fwd_b = 00.
- Stall and flush decisions have zero latency: the controls are valid in the same cycle and are captured at the next falling edge.
- A load-use stall lasts exactly 1 cycle, because the load has advanced to MEM by then.
- MEM wait lasts N cycles for an access whose ready arrives N cycles late. Reaching ERROR takes exactly MEM_TIMEOUT wait cycles.
- If reset is asserted mid-wait, the controller returns to RUN immediately and the counters clear.

## Configuration
- FWD_EN defined:
  - Forwarding mux selects are active. EX/MEM has priority over MEM/WB for the same register.
  - Only load-use hazards stall.
- FWD_EN undefined:
  - fwd_a and fwd_b are tied to 00.
  - Any ID source that matches ex_rd or mem_rd with reg_write set (rd != 0) stalls like a load-use stall.
  - A WB-stage match needs no stall: the register file resolves it with write-before-read.

## Structure
- pipe_ctrl_pkg holds:
  - the FSM state enum
  - the FWD_RF, FWD_EXMEM and FWD_MEMWB select constants
  - the default MEM_TIMEOUT value
- Sub-module pipe_fwd_unit: purely combinational source/destination comparators that produce the fwd selects and the raw-hazard flags.

## Test plan
- Load to x5 in EX, ID reads x5 via rs2 -> pc_en = 0, ifid_en = 0, idex_flush = 1 for 1 cycle; stall_count = 1.
- Load to x0 in EX, ID reads x0 -> no stall.
- Branch taken together with a load-use condition -> ifid_flush = 1, idex_flush = 1, pc_en = 1.
- dmem_req with ready 3 cycles late -> 3 cycles of MEM_WAIT with memwb_bubble = 1; normal outputs in the release cycle.
- dmem_ready never asserted, MEM_TIMEOUT = 4 -> ERROR after 4 cycles with mem_timeout_err = 1; it clears only on reset.
- FWD_EN: mem_rd = wb_rd = x7 = ex_rs1 -> fwd_a = 10. Without FWD_EN, the same case stalls ID.
